// File: rtl/cn_seq.sv
// Channel sequencer: latches N unsigned channels, sorts them with odd-even
// transposition (one pass per cycle), then reduces the sorted set per opcode.
//
// state | meaning
// IDLE  | ready for a request
// SORT  | one odd-even transposition pass per cycle, N passes
// CALC  | reduce sorted channels into out_n/err
// OUT   | present result (one settle cycle, then out_valid until accepted)
module cn_seq #(
  parameter int N  = 6,
  parameter int W  = 4,
  parameter int OW = 2*W+1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic [4:0]      opcode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_n,
  output logic            err
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SORT, CALC, OUT} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    s_q [N];
  logic [W-1:0]    s_d [N];
  logic [CW-1:0]   pass_q, pass_d;
  logic            dir_q, dir_d;
  logic [2:0]      op_q, op_d;
  logic [OW-1:0]   out_n_q, out_n_d;
  logic            err_q, err_d;
  logic            vld_q, vld_d;

  logic [CW-1:0]   pass_idx;
  logic [63:0]     sum_all, sum_lo, sum_hi, res_full;
  logic            res_err;

  // Pass counter runs down to terminal count; parity of the pass index
  // selects even or odd pairs.
  assign pass_idx = CW'(N-1) - pass_q;

  always_comb begin
    sum_all  = '0;
    sum_lo   = '0;
    sum_hi   = '0;
    res_full = '0;
    res_err  = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum_all = sum_all + 64'(s_q[k]);
      if (k < N/2) sum_lo = sum_lo + 64'(s_q[k]);
      else         sum_hi = sum_hi + 64'(s_q[k]);
    end
    case (op_q)
      3'b000: res_full = sum_all;
      3'b001: res_full = dir_q ? 64'(s_q[0]) - 64'(s_q[N-1])
                               : 64'(s_q[N-1]) - 64'(s_q[0]);
      3'b010: res_full = 64'(s_q[0]) * 64'(s_q[1]);
      3'b011: res_full = 64'(s_q[N/2]);
      3'b100: res_full = sum_lo - sum_hi;
      default: begin
        res_full = '0;
        res_err  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    pass_d  = pass_q;
    dir_d   = dir_q;
    op_d    = op_q;
    out_n_d = out_n_q;
    err_d   = err_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < N; k++) s_d[k] = in_data[k*W +: W];
          dir_d   = opcode[4];
          op_d    = opcode[2:0];
          pass_d  = CW'(N-1);
          state_d = SORT;
        end
      end
      SORT: begin
        for (int i = 0; i < N-1; i++) begin
          if (i[0] == pass_idx[0]) begin
            if (dir_q ? (s_q[i] < s_q[i+1]) : (s_q[i] > s_q[i+1])) begin
              s_d[i]   = s_q[i+1];
              s_d[i+1] = s_q[i];
            end
          end
        end
        if (pass_q == '0) state_d = CALC;
        else              pass_d  = pass_q - 1'b1;
      end
      CALC: begin
        out_n_d = res_full[OW-1:0];
        err_d   = res_err;
        state_d = OUT;
      end
      OUT: begin
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int k = 0; k < N; k++) s_q[k] <= '0;
      pass_q  <= '0;
      dir_q   <= 1'b0;
      op_q    <= '0;
      out_n_q <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      pass_q  <= pass_d;
      dir_q   <= dir_d;
      op_q    <= op_d;
      out_n_q <= out_n_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = vld_q;
  assign out_n     = out_n_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cn_seq.sv
// Directed and randomised checks of cn_seq against a sort-and-reduce model.
module tb_cn_seq;

  localparam int N  = 6;
  localparam int W  = 4;
  localparam int OW = 2*W+1;
  localparam int NW = N*W;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [NW-1:0]   in_data;
  logic [4:0]      opcode;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_n;
  logic            err;

  int n_cmp = 0;
  int n_bad = 0;

  cn_seq #(.N(N), .W(W), .OW(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] pk(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5);
    logic [NW-1:0] d;
    d = {W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
    return d;
  endfunction

  // Reference: sort values ascending, reverse for descending, then reduce.
  function automatic void model(input logic [NW-1:0] d, input logic [4:0] op,
                                output logic [OW-1:0] r, output logic e);
    longint v [N];
    longint t, acc, mx, mn;
    for (int k = 0; k < N; k++) v[k] = longint'(d[k*W +: W]);
    for (int i = 1; i < N; i++)
      for (int j = i; j > 0; j--)
        if (v[j-1] > v[j]) begin
          t = v[j]; v[j] = v[j-1]; v[j-1] = t;
        end
    mn = v[0];
    mx = v[N-1];
    if (op[4])
      for (int i = 0; i < N/2; i++) begin
        t = v[i]; v[i] = v[N-1-i]; v[N-1-i] = t;
      end
    acc = 0;
    e   = 1'b0;
    case (op[2:0])
      3'd0: for (int i = 0; i < N; i++) acc += v[i];
      3'd1: acc = mx - mn;
      3'd2: acc = v[0] * v[1];
      3'd3: acc = v[N/2];
      3'd4: for (int i = 0; i < N; i++) acc += (i < N/2) ? v[i] : -v[i];
      default: begin acc = 0; e = 1'b1; end
    endcase
    r = OW'(acc);
  endfunction

  task automatic run_req(input logic [NW-1:0] d, input logic [4:0] op, input int hold,
                         input logic [OW-1:0] er, input logic ee);
    int lat;
    out_ready = 1'b0;
    for (int t = 0; t < 20 && !in_ready; t++) step();
    chk("ready_before_req", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_data  = d;
    opcode   = op;
    step();
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      in_valid = 1'($urandom);
      in_data  = NW'($urandom);
      opcode   = 5'($urandom);
      step();
      if (out_valid) begin
        lat = k;
        break;
      end
      chk("busy_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(N+2));
    chk("out_n", 64'(out_n), 64'(er));
    chk("err", 64'(err), 64'(ee));
    chk("out_in_ready", 64'(in_ready), 64'(0));
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_out_n", 64'(out_n), 64'(er));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_valid", 64'(out_valid), 64'(0));
    chk("post_hs_ready", 64'(in_ready), 64'(1));
    chk("post_hs_out_n", 64'(out_n), 64'(er));
  endtask

  initial begin
    logic [NW-1:0] d;
    logic [4:0]    op;
    logic [OW-1:0] er;
    logic          ee;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; opcode = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_n", 64'(out_n), 64'(0));
    chk("rst_err", 64'(err), 64'(0));

    d = pk(13, 8, 9, 0, 9, 12);
    run_req(d, 5'b00000, 0, 9'd51, 1'b0);
    run_req(d, 5'b00001, 1, 9'd13, 1'b0);
    run_req(d, 5'b10010, 0, 9'd156, 1'b0);
    run_req(d, 5'b00010, 0, 9'd0, 1'b0);
    run_req(d, 5'b00011, 2, 9'd9, 1'b0);
    run_req(d, 5'b00100, 0, 9'd495, 1'b0);
    run_req(d, 5'b00111, 0, 9'd0, 1'b1);
    run_req(d, 5'b01000, 0, 9'd51, 1'b0);

    run_req(pk(3, 4, 7, 5, 2, 14), 5'b00000, 5, 9'd35, 1'b0);

    // abort mid-sort
    in_valid = 1'b1; in_data = pk(13, 8, 9, 0, 9, 12); opcode = 5'b00000;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_out_n", 64'(out_n), 64'(0));
    for (int k = 0; k < 12; k++) begin
      chk("abort_no_valid", 64'(out_valid), 64'(0));
      step();
    end
    run_req(pk(8, 15, 3, 14, 13, 5), 5'b10001, 0, 9'd12, 1'b0);

    // reset beats a simultaneous out_ready
    in_valid = 1'b1; in_data = pk(1, 2, 3, 4, 5, 6); opcode = 5'b00000;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) step();
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("rst_prio_valid", 64'(out_valid), 64'(0));
    chk("rst_prio_out_n", 64'(out_n), 64'(0));
    chk("rst_prio_ready", 64'(in_ready), 64'(1));
    step();
    chk("rst_prio_no_accept", 64'(in_ready), 64'(1));

    for (int r = 0; r < 60; r++) begin
      d = NW'($urandom);
      if ($urandom_range(0, 3) == 0)
        for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom_range(0, 3));
      op = 5'($urandom);
      model(d, op, er, ee);
      run_req(d, op, $urandom_range(0, 3), er, ee);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cn_seq.md
CN_SEQ -- requirements
Module: cn_seq

Interface
REQ-001 Parameter N, default 6, channel count (legal 2..16).
REQ-002 Parameter W, default 4, channel width in bits (legal 1..16).
REQ-003 Parameter OW, default 2*W+1, result width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  request carries valid channels and opcode.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_data  input  N*W  packed unsigned channels; channel k at bits [k*W +: W].
REQ-009 opcode  input  5  [4] sort direction (0 ascending, 1 descending); [3] reserved, ignored; [2:0] operation.
REQ-010 out_valid  output  1  out_n/err hold a completed result.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_n  output  OW  result.
REQ-013 err  output  1  illegal operation code in the completed request.

Function
REQ-014 The FSM SHALL have states IDLE, SORT, CALC and OUT; in_ready SHALL be 1 only in IDLE.
REQ-015 On an accept edge (in_valid & in_ready), in_data and opcode SHALL be latched and the state SHALL go IDLE->SORT; later input changes SHALL NOT affect the result.
REQ-016 in_valid outside IDLE SHALL be ignored (no queueing).
REQ-017 SORT SHALL perform exactly N odd-even transposition passes, one per cycle (even pairs on even pass index, odd pairs on odd), ordering s[0..N-1] per opcode[4], then go to CALC.
REQ-018 CALC SHALL take one cycle, register out_n and err, and go to OUT; out_valid SHALL rise N+2 cycles after the accept edge.
REQ-019 Operations on sorted s[], computed at full precision and truncated to OW bits: 000 sum of all s; 001 largest minus smallest; 010 s[0]*s[1]; 011 s[N/2] (integer division); 100 (sum s[0..N/2-1]) minus (sum s[N/2..N-1]) as two's complement.
REQ-020 Op codes 101, 110, 111 SHALL give out_n=0 and err=1; legal codes SHALL give err=0.
REQ-021 In OUT, out_n and err SHALL stay stable while out_ready=0.
REQ-022 On out_valid & out_ready, state SHALL go OUT->IDLE; out_valid SHALL drop and in_ready SHALL rise on the next cycle; out_n SHALL keep its last value until the next CALC.
REQ-023 Equal channel values SHALL be handled without error; op results SHALL be independent of the permutation of equal values.
REQ-024 Back-to-back throughput SHALL be one request per N+4 cycles at best (accept, N SORT, CALC, OUT handshake).

Reset
REQ-025 While rst=1 at a clock edge, state SHALL become IDLE and in_ready=1, out_valid=0, out_n=0, err=0, and the sort registers SHALL be cleared.
REQ-026 rst asserted in SORT, CALC or OUT SHALL abort the request with no result ever presented for it.
REQ-027 rst SHALL take priority over a simultaneous in_valid or out_ready.

Verification (defaults N=6, W=4, OW=9)
REQ-028 in_data {13,8,9,0,9,12} (channel 0 first), opcode 00000 -> out_n=51, err=0, out_valid exactly 8 cycles after accept.
REQ-029 Same data, opcode 00001 -> 13; opcode 10010 -> 156 (13*12); opcode 00010 -> 0; opcode 00011 -> 9.
REQ-030 Same data, opcode 00100 -> (0+8+9)-(9+12+13)=-17 -> out_n=495; opcode 00111 -> out_n=0, err=1.
REQ-031 {3,4,7,5,2,14}, opcode 00000 with out_ready held 0 for 5 cycles after out_valid -> out_n=35 stable throughout, in_ready=0 throughout; in_valid pulses with other data during busy are ignored.
REQ-032 Accept request, assert rst for 1 cycle at SORT pass 3 -> out_valid never rises for it; in_ready=1 on the cycle after reset; a following request {8,15,3,14,13,5}, opcode 10001 -> 15-3=12.
REQ-033 Randomised back-to-back traffic vs. a reference model, all ops, both directions, random out_ready -> every result matches and no request is lost or duplicated.
